// File: rtl/sme_pkg.sv
// sme_pkg: character constants and FSM state encoding for the string matcher
package sme_pkg;
    localparam logic [7:0] HAT    = 8'h5E;
    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] SPACE  = 8'h20;
    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, REPORT} state_e;
endpackage

// File: rtl/sme_multi_if.sv
// sme_multi_if: character load strobes and match report bus of the string matcher
interface sme_multi_if #(parameter int STR_LEN = 32) ();
    localparam int IW = $clog2(STR_LEN);
    logic [7:0]    chardata;
    logic          isstring;
    logic          ispattern;
    logic          all_mode;
    logic          busy;
    logic          valid;
    logic          match;
    logic [IW-1:0] match_index;
    logic          last;
    modport master (output chardata, isstring, ispattern, all_mode, input busy, valid, match, match_index, last);
    modport slave (input chardata, isstring, ispattern, all_mode, output busy, valid, match, match_index, last);
endinterface

// File: rtl/sme_cand_chk.sv
// sme_cand_chk: head/tail anchor check for one candidate start position
module sme_cand_chk import sme_pkg::*; #(
    parameter int LW = 7
) (
    input  logic [LW-1:0] start,
    input  logic [LW-1:0] plen,
    input  logic [LW-1:0] len,
    input  logic          head,
    input  logic          tail,
    input  logic [7:0]    prev_c,
    input  logic [7:0]    next_c,
    output logic          ok
);
    assign ok = (!head || start == '0 || prev_c == SPACE) &&
                (!tail || start + plen == len || next_c == SPACE);
endmodule

// File: rtl/sme_multi.sv
// sme_multi: anchored wildcard pattern search over a stored string, first or all matches
module sme_multi import sme_pkg::*; #(
    parameter int STR_LEN = 32,
    parameter int PAT_LEN = 8
) (
    input logic       clk,
    input logic       reset,
    sme_multi_if.slave bus
);
    localparam int IW = $clog2(STR_LEN);
    localparam int LW = IW + 2;
    localparam int PW = $clog2(PAT_LEN + 1);
    localparam int KW = $clog2(PAT_LEN);

    logic [7:0] str_mem [STR_LEN];
    logic [7:0] pat_mem [PAT_LEN];

    state_e        state_q, state_d;
    logic [LW-1:0] str_len_q, str_len_d, s_q, s_d;
    logic [PW-1:0] pat_len_q, pat_len_d, k_q, k_d;
    logic          head_q, head_d, tail_q, tail_d, all_q, all_d, pend_q, pend_d;
    logic [IW-1:0] pend_idx_q, pend_idx_d, idx_q, idx_d;
    logic          valid_q, valid_d, match_q, match_d, last_q, last_d;

    logic          str_we, pat_we, cand_ok, bad, at_end, hit;
    logic [LW-1:0] str_base, plen_ext;
    logic [7:0]    str_c, pat_c, prev_c, next_c;

    assign plen_ext = LW'(pat_len_q);
    assign str_base = state_q == LOAD_STR ? str_len_q : '0;
    // Indices wrap modulo STR_LEN; the anchor check ignores wrapped neighbours
    assign str_c    = str_mem[s_q[IW-1:0] + IW'(k_q)];
    assign prev_c   = str_mem[s_q[IW-1:0] - IW'(1)];
    assign next_c   = str_mem[s_q[IW-1:0] + IW'(pat_len_q)];
    assign pat_c    = pat_mem[k_q[KW-1:0]];
    assign bad      = pat_len_q == '0 || plen_ext > str_len_q;
    assign at_end   = s_q > str_len_q - plen_ext;
    assign hit      = cand_ok && (pat_c == DOT || pat_c == str_c);

    sme_cand_chk #(.LW(LW)) u_chk (
        .start(s_q), .plen(plen_ext), .len(str_len_q), .head(head_q), .tail(tail_q),
        .prev_c(prev_c), .next_c(next_c), .ok(cand_ok)
    );

    always_comb begin
        state_d    = state_q;
        str_len_d  = str_len_q;
        pat_len_d  = pat_len_q;
        s_d        = s_q;
        k_d        = k_q;
        head_d     = head_q;
        tail_d     = tail_q;
        all_d      = all_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        valid_d    = 1'b0;
        match_d    = 1'b0;
        idx_d      = '0;
        last_d     = 1'b0;
        str_we     = 1'b0;
        pat_we     = 1'b0;
        case (state_q)
            IDLE, LOAD_STR, LOAD_PAT: begin
                if (bus.isstring) begin
                    state_d   = LOAD_STR;
                    str_we    = str_base < LW'(STR_LEN);
                    str_len_d = str_we ? str_base + 1'b1 : str_base;
                end else if (bus.ispattern) begin
                    state_d = LOAD_PAT;
                    all_d   = (pat_len_q == '0 && !head_q && !tail_q) ? bus.all_mode : all_q;
                    head_d  = head_q | (bus.chardata == HAT);
                    tail_d  = tail_q | (bus.chardata == DOLLAR);
                    pat_we  = bus.chardata != HAT && bus.chardata != DOLLAR && pat_len_q < PW'(PAT_LEN);
                    pat_len_d = pat_we ? pat_len_q + 1'b1 : pat_len_q;
                end else if (state_q == LOAD_PAT) begin
                    state_d = SEARCH;
                    s_d     = '0;
                    k_d     = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                if (bad || at_end) begin
                    state_d = REPORT;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    match_d = pend_q;
                    idx_d   = pend_q ? pend_idx_q : '0;
                end else if (!hit) begin
                    s_d = s_q + 1'b1;
                    k_d = '0;
                end else if (k_q == pat_len_q - PW'(1)) begin
                    s_d = s_q + 1'b1;
                    k_d = '0;
                    // All-mode holds one match back so the final one can carry last
                    if (!all_q || pend_q) begin
                        state_d = REPORT;
                        valid_d = 1'b1;
                        match_d = 1'b1;
                        idx_d   = all_q ? pend_idx_q : s_q[IW-1:0];
                        last_d  = !all_q;
                    end
                    pend_d     = all_q;
                    pend_idx_d = s_q[IW-1:0];
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            REPORT: begin
                state_d   = last_q ? IDLE : SEARCH;
                pat_len_d = last_q ? '0 : pat_len_q;
                head_d    = last_q ? 1'b0 : head_q;
                tail_d    = last_q ? 1'b0 : tail_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            str_len_q  <= '0;
            pat_len_q  <= '0;
            s_q        <= '0;
            k_q        <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            all_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            idx_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            str_len_q  <= str_len_d;
            pat_len_q  <= pat_len_d;
            s_q        <= s_d;
            k_q        <= k_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            all_q      <= all_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            valid_q    <= valid_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (str_we) str_mem[str_base[IW-1:0]] <= bus.chardata;
        if (pat_we) pat_mem[pat_len_q[KW-1:0]] <= bus.chardata;
    end

    assign bus.busy        = state_q == SEARCH || state_q == REPORT;
    assign bus.valid       = valid_q;
    assign bus.match       = match_q;
    assign bus.match_index = idx_q;
    assign bus.last        = last_q;
endmodule

// File: tb/tb_sme_multi.sv
// tb_sme_multi: directed scenarios for the string matcher with hand-computed reports
module tb_sme_multi;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   got_n;
    bit   got_match [8];
    int   got_idx [8];
    bit   got_last [8];
    bit   timeout, gap_err, busy_after;

    always #5 clk = ~clk;

    sme_multi_if #(.STR_LEN(32)) ifc ();
    sme_multi #(.STR_LEN(32), .PAT_LEN(8)) dut (.clk(clk), .reset(reset), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            ifc.chardata = s[i];
            ifc.isstring = 1'b1;
            tick();
        end
        ifc.isstring = 1'b0;
    endtask

    task automatic send_pat(input string p, input bit am);
        for (int i = 0; i < p.len(); i++) begin
            ifc.chardata  = p[i];
            ifc.ispattern = 1'b1;
            ifc.all_mode  = am;
            tick();
        end
        ifc.ispattern = 1'b0;
        ifc.all_mode  = 1'b0;
    endtask

    task automatic capture();
        bit done = 0;
        bit prev_v = 0;
        got_n = 0;
        gap_err = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            tick();
            if (ifc.valid) begin
                if (prev_v) gap_err = 1;
                if (got_n < 8) begin
                    got_match[got_n] = ifc.match;
                    got_idx[got_n]   = int'(ifc.match_index);
                    got_last[got_n]  = ifc.last;
                end
                got_n++;
                if (ifc.last) done = 1;
            end
            prev_v = ifc.valid;
        end
        timeout = !done;
        tick();
        busy_after = ifc.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({ifc.busy, ifc.valid, ifc.match, ifc.last} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {ifc.busy, ifc.valid, ifc.match, ifc.last});
        end
        n_checks++;
        if (ifc.match_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_index got %0d want 0", ifc.match_index);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_head_anchor();
        send_str("hello world");
        send_pat("^wor", 1'b0);
        capture();
        n_checks++;
        if (timeout !== 1'b0 || got_n !== 1) begin
            n_fail++;
            $display("FAIL head_count got %0d (timeout %0b) want 1", got_n, timeout);
        end
        n_checks++;
        if ({got_match[0], got_last[0]} !== 2'b11 || got_idx[0] !== 6) begin
            n_fail++;
            $display("FAIL head_report got m%0b i%0d l%0b want m1 i6 l1", got_match[0], got_idx[0], got_last[0]);
        end
        n_checks++;
        if (busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL head_busy_after got %0b want 0", busy_after);
        end
    endtask

    task automatic test_all_mode();
        send_pat("o", 1'b1);
        capture();
        n_checks++;
        if (got_n !== 2 || gap_err !== 1'b0) begin
            n_fail++;
            $display("FAIL all_count got %0d gap_err %0b want 2 0", got_n, gap_err);
        end
        n_checks++;
        if (got_idx[0] !== 4 || got_idx[1] !== 7 || {got_match[0], got_match[1]} !== 2'b11) begin
            n_fail++;
            $display("FAIL all_idx got %0d,%0d want 4,7", got_idx[0], got_idx[1]);
        end
        n_checks++;
        if ({got_last[0], got_last[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL all_last got %b want 01", {got_last[0], got_last[1]});
        end
    endtask

    task automatic test_tail_and_dot();
        send_pat("ld$", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b11 || got_idx[0] !== 9) begin
            n_fail++;
            $display("FAIL tail_report got n%0d m%0b i%0d want n1 m1 i9", got_n, got_match[0], got_idx[0]);
        end
        send_pat("^h.l", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b11 || got_idx[0] !== 0) begin
            n_fail++;
            $display("FAIL dot_report got n%0d m%0b i%0d want n1 m1 i0", got_n, got_match[0], got_idx[0]);
        end
    endtask

    task automatic test_back_to_back();
        send_str("aaaa");
        send_pat("aa", 1'b1);
        capture();
        n_checks++;
        if (got_n !== 3 || gap_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_count got %0d gap_err %0b want 3 0", got_n, gap_err);
        end
        n_checks++;
        if (got_idx[0] !== 0 || got_idx[1] !== 1 || got_idx[2] !== 2 || {got_last[0], got_last[1], got_last[2]} !== 3'b001) begin
            n_fail++;
            $display("FAIL overlap_idx got %0d,%0d,%0d last %b want 0,1,2 last 001", got_idx[0], got_idx[1], got_idx[2],
                     {got_last[0], got_last[1], got_last[2]});
        end
        send_pat("xyz", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b01 || got_idx[0] !== 0) begin
            n_fail++;
            $display("FAIL nomatch got n%0d m%0b i%0d l%0b want n1 m0 i0 l1", got_n, got_match[0], got_idx[0], got_last[0]);
        end
    endtask

    task automatic test_degenerate();
        send_pat("^$", 1'b1);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL anchors_only got n%0d m%0b l%0b want n1 m0 l1", got_n, got_match[0], got_last[0]);
        end
        send_str("ab");
        send_pat("abc", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b01 || got_idx[0] !== 0) begin
            n_fail++;
            $display("FAIL plen_gt_len got n%0d m%0b i%0d want n1 m0 i0", got_n, got_match[0], got_idx[0]);
        end
    endtask

    task automatic test_overflow_reset();
        int vcount = 0;
        for (int i = 0; i < 40; i++) begin
            ifc.chardata = (i == 35) ? 8'h63 : 8'h62;
            ifc.isstring = 1'b1;
            tick();
        end
        ifc.isstring = 1'b0;
        send_pat("c", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL dropped_char got n%0d m%0b want n1 m0", got_n, got_match[0]);
        end
        send_pat("z", 1'b0);
        tick();
        tick();
        tick();
        n_checks++;
        if (ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_search got %0b want 1", ifc.busy);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({ifc.busy, ifc.valid, ifc.match, ifc.last} !== 4'b0 || ifc.match_index !== 5'd0) begin
            n_fail++;
            $display("FAIL midsearch_reset got %b i%0d want 0000 i0", {ifc.busy, ifc.valid, ifc.match, ifc.last}, ifc.match_index);
        end
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ifc.valid) vcount++;
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++;
            $display("FAIL aborted_valid got %0d pulses want 0", vcount);
        end
        send_str("cab");
        send_pat("b$", 1'b0);
        capture();
        n_checks++;
        if (got_n !== 1 || {got_match[0], got_last[0]} !== 2'b11 || got_idx[0] !== 2) begin
            n_fail++;
            $display("FAIL reload_after_reset got n%0d m%0b i%0d want n1 m1 i2", got_n, got_match[0], got_idx[0]);
        end
    endtask

    initial begin
        ifc.chardata  = 8'h00;
        ifc.isstring  = 1'b0;
        ifc.ispattern = 1'b0;
        ifc.all_mode  = 1'b0;
        test_reset();
        test_head_anchor();
        test_all_mode();
        test_tail_and_dot();
        test_back_to_back();
        test_degenerate();
        test_overflow_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sme_multi.md
SME_MULTI -- requirements
Module: sme_multi

Interface
REQ-001 STR_LEN, 32, maximum stored string characters (power of two, 8..64).
REQ-002 PAT_LEN, 8, maximum stored literal pattern characters, excluding '^' and '$' (2..16).
REQ-003 IW = $clog2(STR_LEN); derived localparam, not overridable.
REQ-004 clk  in  1  clock; all state changes occur on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 chardata  in  8  ASCII character qualified by isstring/ispattern.
REQ-007 isstring  in  1  chardata is a string character.
REQ-008 ispattern  in  1  chardata is a pattern character.
REQ-009 all_mode  in  1  sampled on first pattern char; 1 = report every match, 0 = first match only.
REQ-010 busy  out  1  high from search start until the cycle after the final report.
REQ-011 valid  out  1  one-cycle pulse qualifying match/match_index/last.
REQ-012 match  out  1  1 = match found at match_index.
REQ-013 match_index  out  IW  start index of matched literal text in the string.
REQ-014 last  out  1  final report of the current pattern.

Function
REQ-015 States: IDLE, LOAD_STR, LOAD_PAT, SEARCH, REPORT; reset enters IDLE.
REQ-016 First isstring cycle after any non-isstring cycle clears string length, then stores chars at 0,1,2...; chars beyond STR_LEN are dropped.
REQ-017 isstring and ispattern both high: isstring wins, ispattern ignored that cycle.
REQ-018 Pattern '^' (8'h5E) sets head anchor, '$' (8'h24) sets tail anchor, other chars stored in order; chars beyond PAT_LEN dropped.
REQ-019 '.' (8'h2E) in pattern matches any single string char, including space.
REQ-020 Head anchor satisfied at index i iff i==0 or string[i-1]==8'h20; tail satisfied at end e iff e==len-1 or string[e+1]==8'h20.
REQ-021 SEARCH starts the cycle after the first cycle in LOAD_PAT with both strobes low; no pattern without a new string reuses the last stored string.
REQ-022 Candidate start positions are tried in ascending order 0..len-plen; candidate comparison costs at most PAT_LEN+1 cycles; total search bounded by STR_LEN*(PAT_LEN+1) cycles.
REQ-023 all_mode=0: single valid pulse, last=1, match=1 with lowest qualifying index, or match=0 if none.
REQ-024 all_mode=1: one valid pulse per qualifying index in ascending order, last=1 only on the final one; overlapping matches all reported; none found -> single pulse match=0, last=1.
REQ-025 Consecutive reports separated by at least one cycle with valid=0.
REQ-026 On match=0, match_index=0.
REQ-027 Zero literal chars, plen>len, or empty string -> single pulse match=0, last=1.
REQ-028 isstring/ispattern during SEARCH/REPORT are ignored and not stored.
REQ-029 After last report: return to IDLE, clear anchors and pattern length; string retained.
REQ-030 valid, match, match_index, last are registered outputs.

Reset
REQ-031 Reset forces IDLE; busy, valid, match, last = 0; match_index = 0; string and pattern lengths = 0; anchors cleared.
REQ-032 Reset mid-load or mid-search aborts with no valid pulse; the next string load starts at index 0.
REQ-033 Storage array contents need no reset; lengths gate every read.

Structure
REQ-034 Package sme_pkg holds char constants (HAT, DOLLAR, DOT, SPACE) and the state enum.
REQ-035 One sub-module, sme_cand_chk: combinational anchor/boundary check for one candidate (start, plen, len, neighbour chars -> ok); no out-of-range array index.

Verification (STR_LEN=32, PAT_LEN=8)
REQ-036 String "hello world", pattern "^wor", all_mode=0 -> one pulse: match=1, index=6, last=1.
REQ-037 Same string retained, pattern "o", all_mode=1 -> pulses index 4 then 7; last=1 only on 7.
REQ-038 Pattern "ld$" then "^h.l" with no new string -> index 9, then index 0; each last=1.
REQ-039 String "aaaa", pattern "aa", all_mode=1 -> indices 0, 1, 2; then "xyz" -> match=0, index=0, last=1.
REQ-040 40-char string of 'b' with 'c' at position 35, pattern "c" -> match=0 (char dropped); reset asserted mid-SEARCH -> no valid, all outputs 0 next cycle.
